// File: rtl/acq_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : acq_stream_ctrl
//  Purpose  : Acquisition sequencer for the C2H stream path. Drives the
//             producer dma_rst/dma_ena controls from software start/stop
//             strobes and counts AXIS beats/packets on the monitored link.
//             Supports packet-limited runs and packet-aligned stops.
//  Options  : ACQ_CTRL_WATCHDOG_EN - compiles in the stall watchdog that
//             moves RUN/DRAIN to ERROR after TIMEOUT_CYCLES without a beat.
//  Revision : 1.0 - initial release
// ============================================================================
module acq_stream_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 user_clk,
  input  logic                 user_rstn,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_limit,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 dma_rst,
  output logic                 dma_ena,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] beat_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [7:0]           rst_cnt;
  logic [CNT_WIDTH-1:0] pkt_limit;
  logic [CNT_WIDTH-1:0] pkt_inc;
  logic [CNT_WIDTH-1:0] beat_inc;
  logic                 beat;
  logic                 eop;
  logic                 counting;
  logic                 start_run;
  logic                 rst_last;
  logic                 limit_hit;
  logic                 stall_hit;

  assign beat      = mon_tvalid & mon_tready;
  assign eop       = beat & mon_tlast;
  assign counting  = (state == ST_RUN) || (state == ST_DRAIN);
  // A run only starts from a quiescent state, and a coincident stop cancels it.
  assign start_run = ((state == ST_IDLE) || (state == ST_DONE)) && cfg_start && !cfg_stop;
  assign rst_last  = (rst_cnt == 8'(RST_CYCLES - 1));

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign pkt_inc   = (&pkt_count)  ? pkt_count  : pkt_count  + CNT_WIDTH'(1);
  assign beat_inc  = (&beat_count) ? beat_count : beat_count + CNT_WIDTH'(1);
  assign limit_hit = (pkt_limit != '0) && eop && (pkt_inc == pkt_limit);

`ifdef ACQ_CTRL_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;

  // The final stall clock is the one seen with the counter at LIMIT-1.
  assign stall_hit = counting && !beat && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: runs only while streaming, restarts on every accepted beat.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      stall_cnt <= '0;
    end else if (!counting || beat) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Error flag registered from the next state like the other status outputs.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state_nx == ST_ERROR);
    end
  end
`else
  logic unused_timeout;

  assign stall_hit      = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state decode; stop has priority over start everywhere.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start_run) state_nx = ST_RESET;
      end
      ST_RESET: begin
        if (cfg_stop)      state_nx = ST_IDLE;
        else if (rst_last) state_nx = ST_RUN;
      end
      ST_RUN: begin
        // A limit-reaching eop is already packet aligned, so it beats a stop.
        if (limit_hit)      state_nx = ST_DONE;
        else if (cfg_stop)  state_nx = ST_DRAIN;
        else if (stall_hit) state_nx = ST_ERROR;
      end
      ST_DRAIN: begin
        if (eop)            state_nx = ST_DONE;
        else if (stall_hit) state_nx = ST_ERROR;
      end
      ST_DONE: begin
        if (cfg_stop)       state_nx = ST_IDLE;
        else if (start_run) state_nx = ST_RESET;
      end
      ST_ERROR: begin
        if (cfg_stop) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Reset-pulse length counter, zero whenever not in RESET.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      rst_cnt <= '0;
    end else if (state == ST_RESET) begin
      rst_cnt <= rst_cnt + 8'd1;
    end else begin
      rst_cnt <= '0;
    end
  end

  // Limit latch and beat/packet counters; held outside RUN/DRAIN.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      pkt_limit  <= '0;
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (start_run) begin
      pkt_limit  <= cfg_pkt_limit;
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (counting) begin
      if (beat) beat_count <= beat_inc;
      if (eop)  pkt_count  <= pkt_inc;
    end
  end

  // Registered control/status outputs decoded from the upcoming state.
  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      dma_rst <= 1'b0;
      dma_ena <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      dma_rst <= (state_nx == ST_RESET);
      dma_ena <= (state_nx == ST_RUN);
      busy    <= (state_nx == ST_RESET) || (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
      done    <= (state_nx == ST_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acq_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acq_stream_ctrl
//  Purpose  : Directed self-checking bench for acq_stream_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acq_stream_ctrl;

  localparam int RST_CYCLES     = 4;
  localparam int CNT_WIDTH      = 32;
  localparam int TIMEOUT_CYCLES = 100;

  logic                 user_clk;
  logic                 user_rstn;
  logic                 cfg_start;
  logic                 cfg_stop;
  logic [CNT_WIDTH-1:0] cfg_pkt_limit;
  logic                 mon_tvalid;
  logic                 mon_tready;
  logic                 mon_tlast;
  logic                 dma_rst;
  logic                 dma_ena;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic [CNT_WIDTH-1:0] beat_count;

  int checks = 0;
  int errors = 0;

  acq_stream_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .user_clk     (user_clk),
    .user_rstn    (user_rstn),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_pkt_limit(cfg_pkt_limit),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .dma_rst      (dma_rst),
    .dma_ena      (dma_ena),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .pkt_count    (pkt_count),
    .beat_count   (beat_count)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  // Advance one clock; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_WIDTH-1:0] limit);
    cfg_pkt_limit = limit;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  // Bounded wait for the producer enable; an expired bound is a failure.
  task automatic wait_ena();
    int n = 0;
    while (dma_ena !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (dma_ena !== 1'b1) begin
      errors++;
      $display("FAIL wait_ena: dma_ena=%b after %0d clocks, required 1", dma_ena, n);
    end
  endtask

  task automatic send_beats(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tlast  = last_at_end && (i == n - 1);
      tick();
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({dma_rst, dma_ena, busy, done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000", {dma_rst, dma_ena, busy, done, timeout_err});
    end
    checks++;
    if (pkt_count !== 0 || beat_count !== 0) begin
      errors++;
      $display("FAIL reset_counts: pkt=%0d beat=%0d, required 0 0", pkt_count, beat_count);
    end
  endtask

  task automatic test_basic_run();
    pulse_start(3);
    for (int i = 0; i < RST_CYCLES; i++) begin
      checks++;
      if (dma_rst !== 1'b1 || dma_ena !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_rst_pulse[%0d]: rst=%b ena=%b busy=%b, required 1 0 1", i, dma_rst, dma_ena, busy);
      end
      tick();
    end
    checks++;
    if (dma_rst !== 1'b0 || dma_ena !== 1'b1) begin
      errors++;
      $display("FAIL basic_ena_rise: rst=%b ena=%b, required 0 1", dma_rst, dma_ena);
    end
    send_beats(1024, 1'b1);
    checks++;
    if (pkt_count !== 1 || beat_count !== 1024 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pkt1: pkt=%0d beat=%0d done=%b, required 1 1024 0", pkt_count, beat_count, done);
    end
    send_beats(1024, 1'b1);
    send_beats(1024, 1'b1);
    checks++;
    if (pkt_count !== 3 || beat_count !== 3072) begin
      errors++;
      $display("FAIL basic_counts: pkt=%0d beat=%0d, required 3 3072", pkt_count, beat_count);
    end
    checks++;
    if (done !== 1'b1 || dma_ena !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b ena=%b busy=%b, required 1 0 0", done, dma_ena, busy);
    end
  endtask

  task automatic test_aligned_stop();
    pulse_start(0);
    checks++;
    if (pkt_count !== 0 || beat_count !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_restart_clear: pkt=%0d beat=%0d done=%b, required 0 0 0", pkt_count, beat_count, done);
    end
    wait_ena();
    send_beats(1024, 1'b1);
    send_beats(300, 1'b0);
    // A start strobe mid-run must change nothing.
    pulse_start(7);
    checks++;
    if (dma_rst !== 1'b0 || dma_ena !== 1'b1 || beat_count !== 1324) begin
      errors++;
      $display("FAIL stop_start_ignored: rst=%b ena=%b beat=%0d, required 0 1 1324", dma_rst, dma_ena, beat_count);
    end
    send_beats(200, 1'b0);
    pulse_stop();
    checks++;
    if (dma_ena !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_drain: ena=%b busy=%b done=%b, required 0 1 0", dma_ena, busy, done);
    end
    send_beats(523, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || beat_count !== 2047) begin
      errors++;
      $display("FAIL stop_drain_hold: done=%b busy=%b beat=%0d, required 0 1 2047", done, busy, beat_count);
    end
    send_beats(1, 1'b1);
    checks++;
    if (done !== 1'b1 || pkt_count !== 2 || beat_count !== 2048 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_done: done=%b pkt=%0d beat=%0d busy=%b, required 1 2 2048 0", done, pkt_count, beat_count, busy);
    end
  endtask

  task automatic test_abort_reset();
    int ena_seen = 0;
    pulse_start(0);
    checks++;
    if (dma_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_rst_on: rst=%b, required 1", dma_rst);
    end
    pulse_stop();
    checks++;
    if (dma_rst !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_off: rst=%b busy=%b done=%b, required 0 0 0", dma_rst, busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      if (dma_ena === 1'b1 || dma_rst === 1'b1) ena_seen++;
      tick();
    end
    checks++;
    if (ena_seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: active clocks=%0d, required 0", ena_seen);
    end
  endtask

  task automatic test_start_stop_together();
    cfg_pkt_limit = 5;
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    tick();
    checks++;
    if ({dma_rst, dma_ena, busy, done, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL both_idle: flags=%b, required 00000", {dma_rst, dma_ena, busy, done, timeout_err});
    end
    pulse_start(1);
    wait_ena();
    send_beats(2, 1'b1);
    checks++;
    if (done !== 1'b1 || pkt_count !== 1 || beat_count !== 2) begin
      errors++;
      $display("FAIL both_reach_done: done=%b pkt=%0d beat=%0d, required 1 1 2", done, pkt_count, beat_count);
    end
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    checks++;
    if ({dma_rst, dma_ena, busy, done} !== 4'b0 || pkt_count !== 1 || beat_count !== 2) begin
      errors++;
      $display("FAIL both_done_idle: flags=%b pkt=%0d beat=%0d, required 0000 1 2",
               {dma_rst, dma_ena, busy, done}, pkt_count, beat_count);
    end
  endtask

  task automatic test_watchdog();
    pulse_start(0);
    wait_ena();
    mon_tvalid = 1'b1;
    mon_tready = 1'b0;
`ifdef ACQ_CTRL_WATCHDOG_EN
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    checks++;
    if (timeout_err !== 1'b0 || dma_ena !== 1'b1) begin
      errors++;
      $display("FAIL wd_before: err=%b ena=%b, required 0 1", timeout_err, dma_ena);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || dma_ena !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_fire: err=%b ena=%b busy=%b, required 1 0 0", timeout_err, dma_ena, busy);
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    pulse_start(0);
    checks++;
    if (timeout_err !== 1'b1 || dma_rst !== 1'b0) begin
      errors++;
      $display("FAIL wd_start_ignored: err=%b rst=%b, required 1 0", timeout_err, dma_rst);
    end
    pulse_stop();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wd_stop_idle: err=%b busy=%b done=%b, required 0 0 0", timeout_err, busy, done);
    end
`else
    for (int i = 0; i < TIMEOUT_CYCLES + 50; i++) tick();
    checks++;
    if (timeout_err !== 1'b0 || dma_ena !== 1'b1) begin
      errors++;
      $display("FAIL nowd_stall: err=%b ena=%b, required 0 1", timeout_err, dma_ena);
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b1;
    pulse_stop();
    send_beats(1, 1'b1);
    pulse_stop();
    checks++;
    if ({busy, done, timeout_err} !== 3'b0) begin
      errors++;
      $display("FAIL nowd_cleanup: flags=%b, required 000", {busy, done, timeout_err});
    end
`endif
  endtask

  task automatic test_async_reset();
    pulse_start(0);
    wait_ena();
    send_beats(1024, 1'b1);
    send_beats(10, 1'b0);
    mon_tvalid = 1'b1;
    #2;
    user_rstn = 1'b0;
    #1;
    checks++;
    if ({dma_rst, dma_ena, busy, done, timeout_err} !== 5'b0 || pkt_count !== 0 || beat_count !== 0) begin
      errors++;
      $display("FAIL async_clear: flags=%b pkt=%0d beat=%0d, required 00000 0 0",
               {dma_rst, dma_ena, busy, done, timeout_err}, pkt_count, beat_count);
    end
    mon_tvalid = 1'b0;
    tick();
    tick();
    user_rstn = 1'b1;
    tick();
    pulse_start(1);
    checks++;
    if (pkt_count !== 0 || beat_count !== 0 || dma_rst !== 1'b1) begin
      errors++;
      $display("FAIL async_restart: pkt=%0d beat=%0d rst=%b, required 0 0 1", pkt_count, beat_count, dma_rst);
    end
    wait_ena();
    send_beats(5, 1'b1);
    checks++;
    if (done !== 1'b1 || pkt_count !== 1 || beat_count !== 5) begin
      errors++;
      $display("FAIL async_run: done=%b pkt=%0d beat=%0d, required 1 1 5", done, pkt_count, beat_count);
    end
  endtask

  initial begin
    user_rstn     = 1'b0;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_pkt_limit = '0;
    mon_tvalid    = 1'b0;
    mon_tready    = 1'b1;
    mon_tlast     = 1'b0;
    repeat (3) tick();
    user_rstn = 1'b1;
    tick();

    test_reset();
    test_basic_run();
    test_aligned_stop();
    test_abort_reset();
    test_start_stop_together();
    test_watchdog();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
